// File: rtl/ldpc_llr_loader.sv
// Input stage of the LDPC decoder: saturates streamed channel LLRs into the frame
// register that drives the core's l bus, then runs one decode per frame.
module ldpc_llr_loader #(
  parameter int data_w = 5,
  parameter int in_w   = 8,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int P      = 8,
  parameter int iter_w = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [P*in_w-1:0]       in_data,
  input  logic                    in_last,
  output logic [R*D*data_w-1:0]   l,
  output logic                    core_rst,
  output logic                    core_en,
  input  logic                    core_term,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [iter_w-1:0]       iters
);

  localparam int FL = R * D;
  localparam int NB = FL / P;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
  localparam int SAT = (2 ** (data_w - 1)) - 1;
  localparam logic signed [in_w-1:0] SAT_HI_IN = in_w'(SAT);
  localparam logic signed [in_w-1:0] SAT_LO_IN = in_w'(-SAT);
  localparam logic [data_w-1:0] SAT_HI = data_w'(SAT);
  localparam logic [data_w-1:0] SAT_LO = data_w'(-SAT);
  // The core gets one enable short of counter wrap before the watchdog fires.
  localparam logic [iter_w-1:0] ITER_LIMIT = iter_w'((2 ** iter_w) - 2);

  typedef enum logic [2:0] {IDLE, LOAD, CLR, RUN, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [BW-1:0]     beat;
  logic [data_w-1:0] sat_lane [P];
  logic              load_err;
  logic              wd_err;

  // Symmetric clamp so the most negative code is never handed to the core.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      sat_lane[k] = in_data[k*in_w +: data_w];
      if ($signed(in_data[k*in_w +: in_w]) > SAT_HI_IN)
        sat_lane[k] = SAT_HI;
      else if ($signed(in_data[k*in_w +: in_w]) < SAT_LO_IN)
        sat_lane[k] = SAT_LO;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    core_rst   = 1'b0;
    core_en    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        core_rst   = 1'b1;
        next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_last && beat == LAST_BEAT) next_state = CLR;
      end
      CLR: begin
        core_rst   = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        core_en = ~core_term;
        if (core_term || iters == ITER_LIMIT) next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  assign load_err = (state == LOAD) && in_valid && (in_last != (beat == LAST_BEAT));
  assign wd_err   = (state == RUN) && !core_term && (iters == ITER_LIMIT);

  // A framing error rewinds the beat counter; stale lanes are simply overwritten later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      l         <= '0;
      iters     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= load_err | wd_err;
      if (state == LOAD && in_valid) begin
        for (int k = 0; k < P; k++)
          l[(int'(beat) * P + k) * data_w +: data_w] <= sat_lane[k];
        beat <= (in_last || beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      if (state == CLR)
        iters <= '0;
      else if (core_en)
        iters <= iters + 1'b1;
    end
  end

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Randomized bench for ldpc_llr_loader: a lane-array model of the frame register
// and a counting core model that raises term after a chosen number of enables.
module tb_ldpc_llr_loader;

  localparam int DATA_W = 5;
  localparam int IN_W   = 8;
  localparam int R      = 24;
  localparam int D      = 96;
  localparam int P      = 8;
  localparam int ITER_W = 6;
  localparam int FL     = R * D;
  localparam int NB     = FL / P;
  localparam int WD_LIMIT = (2 ** ITER_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [P*IN_W-1:0]      in_data;
  logic                   in_last;
  logic [FL*DATA_W-1:0]   l;
  logic                   core_rst;
  logic                   core_en;
  logic                   core_term;
  logic                   frame_done;
  logic                   frame_err;
  logic [ITER_W-1:0]      iters;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int frame_in [FL];
  int exp_l    [FL];
  int pattern_in [FL];

  ldpc_llr_loader #(
    .data_w(DATA_W), .in_w(IN_W), .R(R), .D(D), .P(P), .iter_w(ITER_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .l(l), .core_rst(core_rst),
    .core_en(core_en), .core_term(core_term), .frame_done(frame_done),
    .frame_err(frame_err), .iters(iters)
  );

  always #5 clk = ~clk;

  function automatic int satModel(input int v);
    int lim;
    lim = (1 << (DATA_W - 1)) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    assert_cnt++;
    if (obs != exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Compares every lane of l against the model; reports the first bad lane in detail.
  task automatic checkFrame(input string tag);
    int nbad;
    logic signed [DATA_W-1:0] lane;
    nbad = 0;
    for (int i = 0; i < FL; i++) begin
      lane = $signed(l[i*DATA_W +: DATA_W]);
      if (int'(lane) != exp_l[i]) begin
        if (nbad == 0) checkOutput({tag, "_first_bad_lane"}, int'(lane), exp_l[i]);
        nbad++;
      end
    end
    checkOutput({tag, "_bad_lanes"}, nbad, 0);
  endtask

  // Streams beats 0..last_beat with random idle cycles; returns at the negedge after the final beat.
  task automatic applyStimulus(input int last_beat, input bit with_last, input int gap_pct);
    int b;
    int guard;
    b = 0;
    guard = 0;
    while (b <= last_beat && guard < 20000) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (in_ready && ($urandom_range(99) >= gap_pct)) begin
        for (int k = 0; k < P; k++) begin
          in_data[k*IN_W +: IN_W] = IN_W'(frame_in[b*P+k]);
          exp_l[b*P+k] = satModel(frame_in[b*P+k]);
        end
        in_valid = 1'b1;
        in_last  = with_last && (b == last_beat);
        b++;
      end
    end
    checkOutput("load_timeout", guard < 20000, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in the CLR cycle; term_after < 0 means the core never terminates.
  task automatic runDecode(input string tag, input int term_after, input bit exp_wd);
    int en_cnt;
    int cycles;
    int bad_ctl;
    int exp_iters;
    en_cnt = 0;
    cycles = 0;
    bad_ctl = 0;
    checkOutput({tag, "_clr_core_rst"}, core_rst, 1);
    checkOutput({tag, "_clr_in_ready"}, in_ready, 0);
    checkOutput({tag, "_clr_frame_err"}, frame_err, 0);
    @(negedge clk);
    while (!frame_done && cycles < 200) begin
      core_term = (term_after >= 0) && (en_cnt == term_after);
      #1;
      if (core_en) en_cnt++;
      if (core_rst || in_ready || frame_err) bad_ctl++;
      if (core_term && core_en) bad_ctl++;
      @(negedge clk);
      cycles++;
    end
    core_term = 1'b0;
    exp_iters = (term_after < 0 || term_after > WD_LIMIT) ? WD_LIMIT : term_after;
    checkOutput({tag, "_frame_done"}, frame_done, 1);
    checkOutput({tag, "_en_cycles"}, en_cnt, exp_iters);
    checkOutput({tag, "_run_cycles"}, cycles, exp_wd ? WD_LIMIT : term_after + 1);
    checkOutput({tag, "_iters"}, iters, exp_iters);
    checkOutput({tag, "_done_err"}, frame_err, exp_wd);
    checkOutput({tag, "_run_ctl"}, bad_ctl, 0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, frame_done, 0);
    checkOutput({tag, "_back_to_load"}, in_ready, 1);
    checkOutput({tag, "_iters_hold"}, iters, exp_iters);
    checkOutput({tag, "_err_clear"}, frame_err, 0);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < FL; i++) frame_in[i] = int'($urandom_range(255)) - 128;
  endtask

  initial begin
    int sat_vals [8];
    sat_vals = '{127, -128, 15, -15, 16, -16, 0, -1};
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    core_term = 1'b0;
    for (int i = 0; i < FL; i++) exp_l[i] = 0;

    // Reset state and release.
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_core_en", core_en, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_iters", iters, 0);
    checkFrame("rst_l");
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", in_ready, 0);
    checkOutput("rel_core_rst", core_rst, 1);
    @(negedge clk);
    checkOutput("rel1_in_ready", in_ready, 1);
    checkOutput("rel1_core_rst", core_rst, 0);

    // Full back-to-back frame with a lane-index pattern.
    for (int i = 0; i < FL; i++) begin
      pattern_in[i] = i % 16;
      frame_in[i] = pattern_in[i];
    end
    applyStimulus(NB - 1, 1'b1, 0);
    checkFrame("pattern_l");
    runDecode("pattern", 5, 1'b0);

    // Saturation on the first beat, random traffic elsewhere.
    fillRandom();
    for (int k = 0; k < P; k++) frame_in[k] = sat_vals[k];
    applyStimulus(NB - 1, 1'b1, 0);
    checkFrame("sat_l");
    runDecode("sat", int'($urandom_range(20, 1)), 1'b0);

    // Early in_last on beat 100.
    fillRandom();
    applyStimulus(100, 1'b1, 0);
    checkOutput("early_last_err", frame_err, 1);
    checkOutput("early_last_ready", in_ready, 1);
    checkOutput("early_last_no_clr", core_rst, 0);
    checkFrame("early_last_l");
    fillRandom();
    applyStimulus(NB - 1, 1'b1, 0);
    checkFrame("after_early_l");
    runDecode("after_early", 3, 1'b0);

    // Final beat without in_last.
    fillRandom();
    applyStimulus(NB - 1, 1'b0, 0);
    checkOutput("missing_last_err", frame_err, 1);
    checkOutput("missing_last_ready", in_ready, 1);
    fillRandom();
    applyStimulus(NB - 1, 1'b1, 10);
    checkFrame("after_missing_l");
    runDecode("term_now", 0, 1'b0);

    // Watchdog: term never rises.
    fillRandom();
    applyStimulus(NB - 1, 1'b1, 0);
    runDecode("watchdog", -1, 1'b1);

    // Stalled delivery of the pattern frame must give the same l.
    for (int i = 0; i < FL; i++) frame_in[i] = pattern_in[i];
    applyStimulus(NB - 1, 1'b1, 40);
    checkFrame("stall_l");
    runDecode("stall", int'($urandom_range(30, 1)), 1'b0);

    // Reset asserted while the core is running.
    fillRandom();
    applyStimulus(NB - 1, 1'b1, 0);
    repeat (int'($urandom_range(10, 2))) @(negedge clk);
    checkOutput("pre_rst_en", core_en, 1);
    rst = 1'b1;
    #1;
    checkOutput("run_rst_en", core_en, 0);
    checkOutput("run_rst_core_rst", core_rst, 1);
    checkOutput("run_rst_ready", in_ready, 0);
    checkOutput("run_rst_iters", iters, 0);
    for (int i = 0; i < FL; i++) exp_l[i] = 0;
    checkFrame("run_rst_l");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rerel_ready", in_ready, 1);
    fillRandom();
    applyStimulus(NB - 1, 1'b1, 20);
    checkFrame("recover_l");
    runDecode("recover", 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ldpc_llr_loader.md
# ldpc_llr_loader

Upstream input stage of the LDPC decoder. It accepts channel LLRs as a valid/ready stream of P lanes per beat and saturates each to the core's data width. It packs them into the R·D·data_w frame register that drives the core's `l` bus. It then sequences one decode: a per-frame core reset, `en` held until `term`, and a done pulse with the iteration count.

## Interface
Parameters:
- data_w, 5, LLR width delivered to core (two's complement)
- in_w, 8, LLR width on input stream (two's complement)
- R, 24, block columns
- D, 96, circulant size; frame length FL = R·D = 2304 LLRs
- P, 8, LLRs per input beat; FL mod P = 0; NB = FL/P beats per frame (288)
- iter_w, 6, iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  loader accepts beat
- in_data  in  P·in_w  lane k at [k·in_w +: in_w]
- in_last  in  1  marks final beat of frame
- l  out  FL·data_w  packed frame to core
- core_rst  out  1  per-frame core reset
- core_en  out  1  core enable
- core_term  in  1  core termination flag
- frame_done  out  1  one-cycle pulse, decode finished
- frame_err  out  1  one-cycle pulse, framing error or watchdog
- iters  out  iter_w  core_en cycles of last frame, valid at frame_done

## Operation
- States: IDLE, LOAD, CLR, RUN, DONE.
- IDLE (reset state): core_rst=1, in_ready=0; → LOAD next cycle.
- LOAD: in_ready=1. On a handshake (in_valid & in_ready), write lane k to l[(b·P+k)·data_w +: data_w], where b = beat counter; then b++.
  - b==NB-1 with in_last=1: → CLR, b←0.
  - in_last=1 with b<NB-1, or b==NB-1 with in_last=0: frame_err pulse, b←0, stay LOAD. Beats already written are not cleared; the next frame overwrites them.
- Saturation: v<-(2^(data_w-1)-1) → -(2^(data_w-1)-1). v>2^(data_w-1)-1 → 2^(data_w-1)-1. Otherwise truncate to data_w. The range is symmetric; -16 is never produced for data_w=5.
- CLR: core_rst=1 for exactly one cycle, iters←0; → RUN.
- RUN: core_en = (state==RUN) & ~core_term, combinational so no enable cycle follows term. Each cycle with core_en=1, iters++.
  - core_term=1: → DONE.
  - iters reaches 2^iter_w-1 without term: frame_err pulse, → DONE.
- DONE: frame_done=1 for one cycle; iters holds; → LOAD.
- l is written only in LOAD and is stable from CLR through DONE.
- in_ready=0 in IDLE, CLR, RUN and DONE.

## Timing
- Reset values: in_ready=0, core_rst=1, core_en=0, frame_done=0, frame_err=0, iters=0, l=0, b=0, state=IDLE.
- in_ready rises on the first clk edge after rst deasserts.
- Beat throughput is 1/cycle in LOAD. A beat is stored at the edge where in_valid & in_ready.
- Last beat accepted at edge E: CLR in cycle E+1, RUN from E+2.
- core_term seen high at RUN cycle t: core_en=0 in that cycle, DONE in cycle t+1, in_ready=1 at t+2.
- Frame latency is NB + 2 + n + 1 cycles, where n = decode cycles.
- rst mid-frame in any state: immediate return to the reset values. The partial frame is discarded.

## Test plan
- Reset release: check in_ready=0, core_rst=1, l=0. One edge after release, in_ready=1 and core_rst=0.
- Full frame: NB beats with lane value (b·P+k) mod 16, in_last on beat 287; core model raises term after 5 en cycles. Expect l[i]=i mod 16, one CLR cycle, core_en high 5 cycles, frame_done one cycle, iters=5.
- Saturation: lanes +127, -128, +15, -15, +16, -16, 0, -1. Expect l values +15, -15, +15, -15, +15, -15, 0, -1.
- Framing: in_last on beat 100. Expect frame_err pulse, stay LOAD, b=0. A following correct frame decodes normally.
- Watchdog: term never rises. Expect core_en high 63 cycles, frame_err and frame_done in the following DONE, iters=63.
- Stalls and reset: random in_valid gaps give the same l as the back-to-back frame. rst asserted in RUN gives core_en=0 immediately and IDLE state.
